// File: rtl/cpu_pipe_pkg.sv
// rtl/cpu_pipe_pkg.sv - shared stage payload layouts, widths and control-bit indices
package cpu_pipe_pkg;

    localparam int XLEN       = 64;
    localparam int INSTR_W    = 32;
    localparam int REG_ADDR_W = 5;

    // Control-bus bit positions; an all-zero control word is a NOP
    localparam int CTRL_REGWRITE = 0;
    localparam int CTRL_MEMREAD  = 1;
    localparam int CTRL_MEMWRITE = 2;
    localparam int CTRL_MEMREG   = 3;
    localparam int CTRL_BRANCH   = 4;
    localparam int CTRL_JUMP     = 5;

    // Payload layouts as concatenated by each producing stage
    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } if_id_t;

    typedef struct packed {
        logic [XLEN-1:0]       pc;
        logic [XLEN-1:0]       rs1_val;
        logic [XLEN-1:0]       rs2_val;
        logic [XLEN-1:0]       imm;
        logic [REG_ADDR_W-1:0] rd;
    } id_ex_t;

    typedef struct packed {
        logic [XLEN-1:0]       alu_result;
        logic [XLEN-1:0]       store_data;
        logic [XLEN-1:0]       branch_target;
        logic [REG_ADDR_W-1:0] rd;
    } ex_mem_t;

    typedef struct packed {
        logic [XLEN-1:0]       alu_result;
        logic [XLEN-1:0]       load_data;
        logic [REG_ADDR_W-1:0] rd;
    } mem_wb_t;

    localparam int IF_ID_W  = $bits(if_id_t);
    localparam int ID_EX_W  = $bits(id_ex_t);
    localparam int EX_MEM_W = $bits(ex_mem_t);
    localparam int MEM_WB_W = $bits(mem_wb_t);

    // Later stages only carry the control bits they still need to act on
    localparam int IF_ID_CTRL_W  = 1;
    localparam int ID_EX_CTRL_W  = 8;
    localparam int EX_MEM_CTRL_W = CTRL_JUMP + 1;
    localparam int MEM_WB_CTRL_W = CTRL_MEMREG + 1;

endpackage

// File: rtl/pipe_stall_counter.sv
// rtl/pipe_stall_counter.sv - saturating stall-cycle counter with enable
module pipe_stall_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Count enabled cycles, holding at all-ones instead of wrapping
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (en && (count != CNT_MAX)) begin
            count <= count + CNT_ONE;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - valid/ready pipeline-stage register with flush, skid buffer and stall counter
module pipe_stage_reg #(
    parameter int DATA_W = 64,
    parameter int CTRL_W = 8,
    parameter int SKID   = 1,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    input  logic              flush,
    output logic [CNT_W-1:0]  stall_cnt
);

    import cpu_pipe_pkg::*;

    // Main entry always drives the outputs
    logic              main_valid;
    logic [DATA_W-1:0] main_data;
    logic [CTRL_W-1:0] main_ctrl;

    logic accept;
    logic emit;

    assign accept = in_valid && in_ready;
    assign emit   = main_valid && out_ready;

    generate
        if (SKID != 0) begin : g_skid
            logic              skid_valid;
            logic [DATA_W-1:0] skid_data;
            logic [CTRL_W-1:0] skid_ctrl;

            // Ready depends only on registered state, breaking the out_ready -> in_ready path
            assign in_ready = !skid_valid;

            // Two-entry occupancy: skid refills main on emit, otherwise new data lands in main or skid
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    main_valid <= 1'b0;
                    main_data  <= '0;
                    main_ctrl  <= '0;
                    skid_valid <= 1'b0;
                    skid_data  <= '0;
                    skid_ctrl  <= '0;
                end else if (flush) begin
                    main_valid <= 1'b0;
                    main_ctrl  <= '0;
                    skid_valid <= 1'b0;
                    skid_ctrl  <= '0;
                end else if (emit && skid_valid) begin
                    main_valid <= 1'b1;
                    main_data  <= skid_data;
                    main_ctrl  <= skid_ctrl;
                    skid_valid <= 1'b0;
                end else if (accept && (!main_valid || emit)) begin
                    main_valid <= 1'b1;
                    main_data  <= in_data;
                    main_ctrl  <= in_ctrl;
                end else if (accept) begin
                    skid_valid <= 1'b1;
                    skid_data  <= in_data;
                    skid_ctrl  <= in_ctrl;
                end else if (emit) begin
                    main_valid <= 1'b0;
                end
            end
        end else begin : g_single
            // Single register can refill in the same cycle it drains
            assign in_ready = !main_valid || out_ready;

            // One-entry occupancy: accept overwrites main, emit alone empties it
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    main_valid <= 1'b0;
                    main_data  <= '0;
                    main_ctrl  <= '0;
                end else if (flush) begin
                    main_valid <= 1'b0;
                    main_ctrl  <= '0;
                end else if (accept) begin
                    main_valid <= 1'b1;
                    main_data  <= in_data;
                    main_ctrl  <= in_ctrl;
                end else if (emit) begin
                    main_valid <= 1'b0;
                end
            end
        end
    endgenerate

    // A bubble must never present write/branch controls downstream
    assign out_valid = main_valid;
    assign out_data  = main_data;
    assign out_ctrl  = main_valid ? main_ctrl : '0;

    pipe_stall_counter #(
        .CNT_W (CNT_W)
    ) u_stall_counter (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (main_valid && !out_ready),
        .count   (stall_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - scoreboard bench for pipe_stage_reg in skid, single and narrow-counter builds
module tb_pipe_stage_reg;

    localparam int NI = 3;
    localparam int DW = 16;
    localparam int CW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_n;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic [CW-1:0] in_ctrl;
    logic          out_ready;
    logic          flush;

    logic          in_ready_w  [NI];
    logic          out_valid_w [NI];
    logic [DW-1:0] out_data_w  [NI];
    logic [CW-1:0] out_ctrl_w  [NI];
    logic [31:0]   stall_w     [NI];
    logic [3:0]    sat_cnt;

    assign stall_w[2] = {28'd0, sat_cnt};

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .CNT_W(32)) u_skid (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready_w[0]),
        .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(out_valid_w[0]), .out_ready(out_ready),
        .out_data(out_data_w[0]), .out_ctrl(out_ctrl_w[0]), .flush(flush), .stall_cnt(stall_w[0]));

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(0), .CNT_W(32)) u_single (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready_w[1]),
        .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(out_valid_w[1]), .out_ready(out_ready),
        .out_data(out_data_w[1]), .out_ctrl(out_ctrl_w[1]), .flush(flush), .stall_cnt(stall_w[1]));

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .CNT_W(4)) u_sat (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready_w[2]),
        .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(out_valid_w[2]), .out_ready(out_ready),
        .out_data(out_data_w[2]), .out_ctrl(out_ctrl_w[2]), .flush(flush), .stall_cnt(sat_cnt));

    // Reference model: each instance is a FIFO of {data,ctrl} with a capacity rule
    logic [DW+CW-1:0] exp_q [NI][$];
    logic             pend_acc [NI];
    logic             pend_flush;
    longint           mcnt [NI];

    int n_cmp = 0;
    int n_bad = 0;

    function automatic logic model_ready(input int i);
        if (i == 1) return (exp_q[i].size() == 0) || out_ready;
        return exp_q[i].size() < 2;
    endfunction

    function automatic longint cnt_max(input int i);
        return (i == 2) ? 64'd15 : 64'hFFFF_FFFF;
    endfunction

    task automatic check(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s inst%0d at %0t: got 0x%0h expected 0x%0h", name, i, $time, act, exp);
        end
    endtask

    // Monitor: compare what the DUT presents against the model, pop on emit
    always @(negedge clk) begin : mon
        logic [DW+CW-1:0] head;
        logic             exp_v;
        for (int i = 0; i < NI; i++) begin
            if (!reset_n) begin
                check("rst_out_valid", i, 32'(out_valid_w[i]), 32'd0);
                check("rst_out_data",  i, 32'(out_data_w[i]),  32'd0);
                check("rst_out_ctrl",  i, 32'(out_ctrl_w[i]),  32'd0);
                check("rst_stall_cnt", i, stall_w[i],          32'd0);
                check("rst_in_ready",  i, 32'(in_ready_w[i]),  32'd1);
                mcnt[i] = 0;
            end else begin
                exp_v = exp_q[i].size() > 0;
                check("in_ready",  i, 32'(in_ready_w[i]),  32'(model_ready(i)));
                check("out_valid", i, 32'(out_valid_w[i]), 32'(exp_v));
                check("stall_cnt", i, stall_w[i],          32'(mcnt[i]));
                if (exp_v) begin
                    head = exp_q[i][0];
                    check("out_data", i, 32'(out_data_w[i]), 32'(head[DW+CW-1:CW]));
                    check("out_ctrl", i, 32'(out_ctrl_w[i]), 32'(head[CW-1:0]));
                    if (out_ready) begin
                        void'(exp_q[i].pop_front());
                    end else if (mcnt[i] < cnt_max(i)) begin
                        mcnt[i] = mcnt[i] + 1;
                    end
                end else begin
                    check("bubble_ctrl", i, 32'(out_ctrl_w[i]), 32'd0);
                end
            end
        end
    end

    // Apply last cycle's accepts/flush to the model, then drive a new cycle
    task automatic drive(input logic iv, input logic [DW-1:0] d, input logic [CW-1:0] c,
                         input logic ordy, input logic fl);
        @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) begin
            if (pend_flush) exp_q[i].delete();
            else if (pend_acc[i]) exp_q[i].push_back({in_data, in_ctrl});
        end
        in_valid  = iv;
        in_data   = d;
        in_ctrl   = c;
        out_ready = ordy;
        flush     = fl;
        for (int i = 0; i < NI; i++) pend_acc[i] = iv && model_ready(i);
        pend_flush = fl;
    endtask

    // Asynchronous reset asserted between clock edges, while the stage may be full
    task automatic do_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        for (int i = 0; i < NI; i++) begin
            exp_q[i].delete();
            pend_acc[i] = 1'b0;
        end
        pend_flush = 1'b0;
        in_valid   = 1'b0;
        flush      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n    = 1'b1;
        in_valid   = 1'b0;
        in_data    = '0;
        in_ctrl    = '0;
        out_ready  = 1'b0;
        flush      = 1'b0;
        pend_flush = 1'b0;
        for (int i = 0; i < NI; i++) pend_acc[i] = 1'b0;
        #2 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        // Streaming at full rate
        for (int k = 0; k < 8; k++) drive(1'b1, DW'(16'h10 + k), 8'h01, 1'b1, 1'b0);
        repeat (2) drive(1'b0, '0, '0, 1'b1, 1'b0);

        // Back-pressure filling the skid entry
        drive(1'b1, 16'h00A0, 8'h01, 1'b1, 1'b0);
        drive(1'b1, 16'h00A1, 8'h01, 1'b0, 1'b0);
        repeat (2) drive(1'b0, '0, '0, 1'b0, 1'b0);
        repeat (3) drive(1'b0, '0, '0, 1'b1, 1'b0);

        // Flush with both entries held and a new instruction offered
        drive(1'b1, 16'h00B0, 8'h05, 1'b0, 1'b0);
        drive(1'b1, 16'h00B1, 8'h05, 1'b0, 1'b0);
        drive(1'b1, 16'h00B2, 8'h05, 1'b0, 1'b1);
        repeat (2) drive(1'b0, '0, '0, 1'b1, 1'b0);

        // Same-cycle accept and emit while full, then flush during an emit
        drive(1'b1, 16'h00C0, 8'h09, 1'b0, 1'b0);
        drive(1'b1, 16'h00C1, 8'h09, 1'b0, 1'b0);
        drive(1'b1, 16'h00C2, 8'h09, 1'b1, 1'b0);
        drive(1'b1, 16'h00C3, 8'h09, 1'b1, 1'b1);
        repeat (2) drive(1'b0, '0, '0, 1'b1, 1'b0);

        // Long stall to saturate the narrow counter
        drive(1'b1, 16'h00D0, 8'h11, 1'b0, 1'b0);
        repeat (20) drive(1'b0, '0, '0, 1'b0, 1'b0);
        repeat (3) drive(1'b0, '0, '0, 1'b1, 1'b0);

        // Reset mid-stream with entries held
        drive(1'b1, 16'h00E0, 8'h21, 1'b0, 1'b0);
        drive(1'b1, 16'h00E1, 8'h21, 1'b0, 1'b0);
        drive(1'b1, 16'h00E2, 8'h21, 1'b0, 1'b0);
        do_reset();

        // Randomised traffic with occasional flushes and one more reset
        for (int k = 0; k < 1500; k++) begin
            if (k == 700) do_reset();
            drive(($urandom % 4) != 0, DW'($urandom), CW'($urandom),
                  ($urandom % 3) != 0, ($urandom % 20) == 0);
        end
        repeat (4) drive(1'b0, '0, '0, 1'b1, 1'b0);

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
